// File: rtl/inst_encoder.sv
// RV32I instruction-word packer with an output FIFO of {word, word address}.
// Optional `INM_ROUNDTRIP_CHECK_EN re-extracts the immediate from the packed word and flags disagreement.
module inst_encoder #(
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_inm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic [2:0]        err_code
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
  } fmt_t;

  logic [31:0]       r_mem_inst [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_occ;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W:0]   r_count;
  logic              r_err;
  logic [2:0]        r_err_code;

  logic signed [31:0] w_imm;
  logic [31:0]        w_word;
  logic [2:0]         w_code;
  logic               w_range_bad;
  logic               w_align_bad;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_imm = in_inm;

  always_comb begin
    w_word      = 32'd0;
    w_range_bad = 1'b0;
    w_align_bad = 1'b0;
    case (fmt_t'(in_fmt))
      FMT_R: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        w_word      = {in_inm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_range_bad = (w_imm > 32'sd2047) || (w_imm < -32'sd2048);
      end
      FMT_S: begin
        w_word      = {in_inm[11:5], in_rs2, in_rs1, in_funct3, in_inm[4:0], in_opcode};
        w_range_bad = (w_imm > 32'sd2047) || (w_imm < -32'sd2048);
      end
      FMT_B: begin
        w_word      = {in_inm[12], in_inm[10:5], in_rs2, in_rs1, in_funct3,
                       in_inm[4:1], in_inm[11], in_opcode};
        w_range_bad = (w_imm > 32'sd4094) || (w_imm < -32'sd4096);
        w_align_bad = in_inm[0];
      end
      FMT_U: begin
        w_word      = {in_inm[31:12], in_rd, in_opcode};
        w_align_bad = (in_inm[11:0] != 12'd0);
      end
      FMT_J: begin
        w_word      = {in_inm[20], in_inm[10:1], in_inm[11], in_inm[19:12], in_rd, in_opcode};
        w_range_bad = (w_imm > 32'sd1048574) || (w_imm < -32'sd1048576);
        w_align_bad = in_inm[0];
      end
      default: w_word = 32'd0;
    endcase
  end

`ifdef INM_ROUNDTRIP_CHECK_EN
  logic [31:0] w_rt_imm;
  logic        w_rt_bad;

  always_comb begin
    w_rt_imm = in_inm;
    case (fmt_t'(in_fmt))
      FMT_I:   w_rt_imm = {{20{w_word[31]}}, w_word[31:20]};
      FMT_S:   w_rt_imm = {{20{w_word[31]}}, w_word[31:25], w_word[11:7]};
      FMT_B:   w_rt_imm = {{19{w_word[31]}}, w_word[31], w_word[7], w_word[30:25],
                           w_word[11:8], 1'b0};
      FMT_U:   w_rt_imm = {w_word[31:12], 12'd0};
      FMT_J:   w_rt_imm = {{11{w_word[31]}}, w_word[31], w_word[19:12], w_word[20],
                           w_word[30:21], 1'b0};
      default: w_rt_imm = in_inm;
    endcase
    w_rt_bad = (w_rt_imm != in_inm);
  end
`else
  logic w_rt_bad;
  assign w_rt_bad = 1'b0;
`endif

  always_comb begin
    if (in_fmt > 3'd5)    w_code = 3'd3;
    else if (w_range_bad) w_code = 3'd1;
    else if (w_align_bad) w_code = 3'd2;
    else if (w_rt_bad)    w_code = 3'd4;
    else                  w_code = 3'd0;
  end

  // Pops never make room for a same-cycle push: in_ready looks only at registered occupancy.
  assign in_ready  = (r_occ != (PTR_W+1)'(FIFO_DEPTH));
  assign out_valid = (r_occ != '0);
  assign out_inst  = out_valid ? r_mem_inst[r_rd_ptr] : 32'd0;
  assign out_addr  = out_valid ? r_mem_addr[r_rd_ptr] : r_wr_addr;
  assign count     = r_count;
  assign err       = r_err;
  assign err_code  = r_err_code;

  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && (w_code == 3'd0);
  assign w_pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_wr_addr  <= ADDR_W'(BASE_ADDR);
      r_count    <= '0;
      r_err      <= 1'b0;
      r_err_code <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_wr_addr <= r_wr_addr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count  <= sat_inc(r_count);
      end
      if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
      else if (w_pop && !w_push) r_occ <= r_occ - 1'b1;
      if (w_accept && (w_code != 3'd0)) begin
        r_err <= 1'b1;
        if (!r_err) r_err_code <= w_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst && !flush) begin
      r_mem_inst[r_wr_ptr] <= w_word;
      r_mem_addr[r_wr_ptr] <= r_wr_addr;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: expected {word, address} queued on accept, compared on pop.
module tb_inst_encoder;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready;
  logic [2:0]        in_fmt, in_funct3;
  logic [6:0]        in_opcode, in_funct7;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [31:0]       in_inm;
  logic              out_valid, out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic [ADDR_W:0]   count;
  logic              err;
  logic [2:0]        err_code;

  typedef struct packed {
    logic [31:0]       inst;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t            sb[$];
  int                n_checks = 0;
  int                n_fail = 0;
  int                mon_pops = 0;
  int                pops_base = 0;
  logic [ADDR_W-1:0] exp_addr = '0;

  inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_inm(in_inm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .count(count), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Golden packer built from shifts and masks on the raw immediate.
  function automatic logic [31:0] model_word(input logic [31:0] fmt, input logic [31:0] op,
      input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
      input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] imm);
    logic [31:0] base;
    base = (rs1 << 15) | (f3 << 12) | op;
    case (fmt)
      0: return (f7 << 25) | (rs2 << 20) | (rd << 7) | base;
      1: return ((imm & 32'hFFF) << 20) | (rd << 7) | base;
      2: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | ((imm & 32'h1F) << 7) | base;
      3: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | base;
      4: return (imm & 32'hFFFFF000) | (rd << 7) | op;
      default: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 11) & 1) << 20) | (imm & 32'h000FF000) | (rd << 7) | op;
    endcase
  endfunction

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      mon_pops++;
      if (sb.size() == 0) begin
        check_eq("unexpected_pop", 64'd1, 64'd0);
      end else begin
        entry_t e;
        e = sb.pop_front();
        check_eq("pop_inst", 64'(out_inst), 64'(e.inst));
        check_eq("pop_addr", 64'(out_addr), 64'(e.addr));
      end
    end
  end

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] imm, input bit ok, input logic [31:0] word);
    int t;
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_inm = imm; in_valid = 1'b1;
    for (t = 0; t < 200 && !in_ready; t++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) begin
      check_eq("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (ok) begin
      sb.push_back('{inst: word, addr: exp_addr});
      exp_addr = exp_addr + 1'b1;
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    out_ready = 1'b1;
    for (t = 0; t < 100 && (out_valid || sb.size() != 0); t++) begin
      @(posedge clk); #1;
    end
    check_eq("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_flush();
    logic keep;
    keep = out_ready;
    out_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    exp_addr = '0;
    pops_base = mon_pops;
    out_ready = keep;
  endtask

  task automatic send_rand();
    logic [31:0] r, imm;
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    r = $urandom;
    fmt = 3'($urandom_range(0, 5));
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    f3 = 3'($urandom); f7 = 7'($urandom); op = 7'($urandom);
    case (fmt)
      3'd1, 3'd2: imm = {{20{r[11]}}, r[11:0]};
      3'd3:       imm = {{19{r[12]}}, r[12:1], 1'b0};
      3'd4:       imm = {r[31:12], 12'd0};
      3'd5:       imm = {{11{r[20]}}, r[20:1], 1'b0};
      default:    imm = r;
    endcase
    send(fmt, op, rd, rs1, rs2, f3, f7, imm, 1'b1,
         model_word(32'(fmt), 32'(op), 32'(rd), 32'(rs1), 32'(rs2), 32'(f3), 32'(f7), imm));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_inm = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_inst", 64'(out_inst), 64'd0);
    check_eq("rst_out_addr", 64'(out_addr), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    check_eq("rst_err_code", 64'(err_code), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    out_ready = 1'b1;

    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00093);
    check_eq("i_lat_valid", 64'(out_valid), 64'd1);
    check_eq("i_inst", 64'(out_inst), 64'hFFF00093);
    check_eq("i_addr", 64'(out_addr), 64'd0);
    send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 1'b1, 32'h001000EF);
    check_eq("j_inst", 64'(out_inst), 64'h001000EF);
    check_eq("j_addr", 64'(out_addr), 64'd1);
    send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b1, 32'h00208463);
    check_eq("b_inst", 64'(out_inst), 64'h00208463);
    send(3'd4, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123450B7);
    check_eq("u_inst", 64'(out_inst), 64'h123450B7);
    send(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'b0100000, 32'hDEADBEEF, 1'b1, 32'h403100B3);
    check_eq("r_inst", 64'(out_inst), 64'h403100B3);
    drain();
    check_eq("legal_err", 64'(err), 64'd0);

    send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd2048, 1'b0, 32'd0);
    check_eq("s_range_nowrite", 64'(out_valid), 64'd0);
    check_eq("s_range_err", 64'(err), 64'd1);
    check_eq("s_range_code", 64'(err_code), 64'd1);
    send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0, 32'd0);
    check_eq("sticky_code", 64'(err_code), 64'd1);
    check_eq("sticky_nowrite", 64'(out_valid), 64'd0);
    do_flush();
    check_eq("flush_err", 64'(err), 64'd0);
    check_eq("flush_code", 64'(err_code), 64'd0);
    check_eq("flush_addr", 64'(out_addr), 64'd0);
    check_eq("flush_count", 64'(count), 64'd0);
    send(3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
    check_eq("fmt6_code", 64'(err_code), 64'd3);
    do_flush();
    send(3'd4, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 1'b0, 32'd0);
    check_eq("u_align_code", 64'(err_code), 64'd2);
    do_flush();
    send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 1'b0, 32'd0);
    check_eq("j_range_code", 64'(err_code), 64'd1);
    do_flush();
    send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFF000, 1'b1,
         model_word(32'd3, 32'h63, 32'd0, 32'd1, 32'd2, 32'd0, 32'd0, 32'hFFFFF000));
    check_eq("b_min_err", 64'(err), 64'd0);
    drain();
    do_flush();

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(3'd1, 7'b0010011, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), 1'b1,
           model_word(32'd1, 32'h13, 32'(i + 1), 32'd0, 32'd0, 32'd0, 32'd0, 32'(i)));
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check_eq("hold_inst", 64'(out_inst), 64'(sb[0].inst));
    check_eq("hold_addr", 64'(out_addr), 64'd0);
    check_eq("full_in_ready2", 64'(in_ready), 64'd0);
    fork
      send(3'd1, 7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 1'b1,
           model_word(32'd1, 32'h13, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd4));
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("bp_count", 64'(count), 64'd5);

    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) send_rand();
    check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_count", 64'(count), 64'd0);
    check_eq("mid_rst_addr", 64'(out_addr), 64'd0);
    sb.delete();
    exp_addr = '0;
    pops_base = mon_pops;

    for (int i = 0; i < 2050; i++) begin
      out_ready = ($urandom_range(0, 3) != 0) || !in_ready;
      send_rand();
    end
    drain();
    check_eq("stream_pops", 64'(mon_pops - pops_base), 64'd2050);
    check_eq("count_sat", 64'(count), 64'd2047);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Instruction-word packer, the inverse of the core's immediate generator.
- Accepts decoded fields (format, opcode, rd, rs1, rs2, funct3, funct7, sign-extended immediate) over a valid/ready handshake.
- Range-checks the immediate, scatters it into RV32I R/I/S/B/U/J bit positions, and queues the 32-bit word with its target word address in an output FIFO.
- Used by the boot/program loader to fill instruction memory, and by the verification bench as a golden assembler.

Parameters:
ADDR_W, 10, word-address width of out_addr.
BASE_ADDR, 0, first word address after reset or flush.
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous clear of FIFO, address counter and error
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&&in_ready
in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
in_opcode  in  7  placed in bits [6:0]
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_funct3  in  3  funct3
in_funct7  in  7  funct7 (R only)
in_inm  in  32  sign-extended immediate (U: full value, low 12 bits zero)
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer pop
out_inst  out  32  packed instruction at FIFO head
out_addr  out  ADDR_W  word address of FIFO head
count  out  ADDR_W+1  words popped since reset/flush, saturating
err  out  1  sticky error
err_code  out  3  first error cause: 0 none, 1 range, 2 alignment, 3 illegal fmt, 4 roundtrip

Behaviour:
- Reset (rst=1 at edge): FIFO empty, out_valid=0, out_inst=0, out_addr=BASE_ADDR, count=0, err=0, err_code=0, write address=BASE_ADDR. Reset mid-transfer discards all queued words.
- in_ready = !fifo_full. Pops in the same cycle do not free space for a push; a full FIFO never accepts.
- Accept cycle N: encode and check combinationally. A legal word is written at edge N. out_valid rises at N+1 if the FIFO was empty (latency 1).
- Packing:
  - R: {f7,rs2,rs1,f3,rd,op}
  - I: {imm[11:0],rs1,f3,rd,op}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - U: {imm[31:12],rd,op}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
  - Unused fields are ignored.
- Checks, in priority order:
  - illegal fmt → code 3
  - range: I/S in [-2048,2047], B in [-4096,4094], J in [-2^20,2^20-2] → code 1
  - alignment: B/J imm[0]=1, or U imm[11:0]!=0 → code 2
  - R ignores in_inm.
- Error handling:
  - A failing request is still handshaken (consumed), but no FIFO write occurs and the address does not advance.
  - err is set; err_code latches only when err was 0.
- Each legal write stores {word, wr_addr}. wr_addr increments by 1 and wraps modulo 2^ADDR_W (BASE_ADDR only on reset/flush).
- Pop when out_valid&&out_ready. count increments on each pop and saturates at 2^(ADDR_W+1)-1.
- Simultaneous push and pop on a non-full FIFO: both occur, occupancy unchanged.
- flush: same effect as reset except count also clears. Overrides push/pop that cycle; in_ready stays valid.
- FIFO is first-in first-out; out_inst/out_addr hold stable while out_valid&&!out_ready.

Optional Feature:
INM_ROUNDTRIP_CHECK_EN
- Defined: an internal extractor re-derives the sign-extended immediate from the packed word (I/S/B/U/J rules) and compares it to in_inm. On mismatch, with no higher-priority error, the request is dropped as an error with code 4.
- Undefined: no extractor; code 4 never produced.

Test Plan:
- I: fmt=1, op=0010011, rd=1, rs1=0, f3=0, inm=0xFFFFFFFF → next cycle out_valid=1, out_inst=0xFFF00093, out_addr=0.
- B: fmt=3, op=1100011, rs1=1, rs2=2, f3=0, inm=8 → out_inst=0x00208463. J: fmt=5, op=1101111, rd=1, inm=0x800 → out_inst=0x001000EF at out_addr=1.
- S with inm=2048 → no write, err=1, err_code=1. Then B with inm=3 → err_code stays 1. Then flush → err=0, out_addr=0, count=0.
- Backpressure, FIFO_DEPTH=4, out_ready=0, five requests → in_ready low after the 4th accept. Release → addresses 0,1,2,3, then 4, in order; count=5.
- Full-edge wrap: ADDR_W=2, six legal words → out_addr sequence 0,1,2,3,0,1. rst asserted with 2 queued → out_valid=0 next cycle, count=0.
- With INM_ROUNDTRIP_CHECK_EN, U with inm=0x12345000 → no error, out_inst=0x123450B7 (rd=1, op=0110111). fmt=6 → err_code=3.
